alu_cmd_sequencer: RTL
======================

Name: alu_cmd_sequencer

Overview:
- Command-side driver for the 4-bit combinational ALU; owns the operand register file and issues operations to the ALU.
- Accepts register-addressed commands over a valid/ready interface and drives the ALU's A, B and opcode inputs from registers.
- Captures the ALU result and zero flag, writes the result back to a 4-entry x 4-bit register file, and returns it over a valid/ready response interface.
- The ALU is instantiated alongside this block at the top level, not inside it.

Parameters:
- DATA_W, 4, operand/result width; must match the ALU.
- OP_W, 3, ALU opcode width.
- NREGS, 4, register file depth.
- REG_AW, 2, register address width, log2(NREGS).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  OP_W  ALU opcode, passed to the ALU unchanged.
- cmd_rd  in  REG_AW  destination register.
- cmd_rs1  in  REG_AW  source register for operand A.
- cmd_rs2  in  REG_AW  source register for operand B.
- cmd_use_imm  in  1  when 1, B = cmd_imm instead of regs[rs2].
- cmd_imm  in  DATA_W  immediate operand.
- cmd_wb_en  in  1  when 1, write the result to regs[rd].
- alu_a  out  DATA_W  registered ALU operand A.
- alu_b  out  DATA_W  registered ALU operand B.
- alu_op  out  OP_W  registered ALU opcode.
- alu_result  in  DATA_W  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_W  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_rd  out  REG_AW  destination register of this response.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - All register file entries = 0.
  - alu_a, alu_b, alu_op, rsp_data, rsp_zero, rsp_rd = 0.
  - rsp_valid = 0, busy = 0; cmd_ready = 1 once reset deasserts.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready at edge T: alu_a <= regs[rs1]; alu_b <= use_imm ? imm : regs[rs2]; alu_op <= cmd_op.
  - Also latch rd and wb_en internally, then go to EXEC.
- EXEC (one cycle):
  - The ALU settles combinationally during this cycle.
  - At edge T+1: rsp_data <= alu_result; rsp_zero <= alu_zero; rsp_rd <= latched rd.
  - If wb_en: regs[rd] <= alu_result.
  - rsp_valid <= 1, then go to RESP.
- RESP:
  - rsp_valid = 1; rsp_data, rsp_zero and rsp_rd are held stable.
  - On rsp_ready at an edge: rsp_valid <= 0 and go to IDLE.
- Latency and throughput:
  - rsp_valid is first visible in the cycle after edge T+1.
  - Best-case throughput is one command per 3 cycles.
- cmd_ready = 1 only in IDLE. Commands presented in EXEC or RESP are not accepted and have no effect.
- alu_a, alu_b and alu_op hold their last values outside EXEC (no toggling).
- Read-after-write needs no forwarding: writeback completes at T+1, before the next accept at T+3 or later.
- Width rules:
  - Arithmetic is the ALU's; the block never modifies the result.
  - Wrap-around is inherited, e.g. ADD 0xF + 0x1 = 0x0 with zero = 1.
- rd == rs1 or rd == rs2 is legal: sources are read at accept time, the destination is written in EXEC.
- wb_en = 0: the response is still produced; the register file is unchanged.
- Reset mid-EXEC or mid-RESP: the pending response is dropped, there is no writeback, and the register file clears.
- The register file has no hardwired-zero entry; r0 is an ordinary register.

Decomposition:
- Shared package alu_pkg:
  - DATA_W and OP_W.
  - Opcode constants: ADD=000, SUB=001, AND=010, OR=011, XOR=100, NAND=101, NOR=110, SLT=111.
  - FSM state encoding: IDLE, EXEC, RESP.
- One natural sub-module, alu_regfile:
  - NREGS x DATA_W.
  - Two combinational read ports and one synchronous write port.
  - Asynchronous active-low clear.

Test Plan:
- Reset: assert rst_n = 0 mid-run -> cmd_ready = 1, rsp_valid = 0, busy = 0, alu_a = alu_b = alu_op = 0, all registers read 0.
- Immediate load and wrap:
  - ADD rd=1 rs1=0 imm=5 wb=1 -> rsp_data = 5, rsp_zero = 0, rsp_rd = 1, rsp_valid 2 edges after accept.
  - Then ADD rd=2 rs1=1 imm=0xC -> rsp_data = 0x1; r2 = 1.
- Zero flag and self-operand: SUB rd=3 rs1=1 rs2=1 wb=1 -> rsp_data = 0, rsp_zero = 1, r3 = 0.
- No-writeback compare: SLT rd=1 rs1=0 imm=3 wb=0 -> rsp_data = 1, rsp_zero = 0; r1 still 5 (confirm with ADD rd=0 rs1=1 imm=0 -> 5).
- Backpressure:
  - rsp_ready = 0 for 5 cycles with cmd_valid held high -> rsp_valid stays 1, data/zero/rd stable, cmd_ready = 0, no second accept.
  - Raise rsp_ready -> IDLE next cycle, and the held command is accepted one cycle later.
- Reset during EXEC: accept ADD rd=2 imm=7, pull rst_n low the cycle after accept -> rsp_valid never rises, r2 = 0 after reset.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes and sequencer state encoding
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int OP_W   = 3;
    localparam int NREGS  = 4;
    localparam int REG_AW = 2;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_AND  = 3'b010;
    localparam logic [OP_W-1:0] OP_OR   = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_NAND = 3'b101;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b110;
    localparam logic [OP_W-1:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - operand register file, two async read ports, one sync write port
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] i_raddr1,
    output logic [DATA_W-1:0] o_rdata1,
    input  logic [REG_AW-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata2,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - issues register-addressed commands to an external ALU and returns results
module alu_cmd_sequencer
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_rs1,
    input  logic [REG_AW-1:0] cmd_rs2,
    input  logic              cmd_use_imm,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic              cmd_wb_en,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic [REG_AW-1:0] rsp_rd,
    output logic              busy
);

    seq_state_t        r_state;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic [REG_AW-1:0] r_rd;
    logic              r_wb_en;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_zero;
    logic [REG_AW-1:0] r_rsp_rd;

    logic [DATA_W-1:0] w_rs1_data;
    logic [DATA_W-1:0] w_rs2_data;
    logic              w_wb;

    // Writeback lands on the EXEC->RESP edge, so a later accept never needs forwarding.
    assign w_wb = (r_state == ST_EXEC) && r_wb_en;

    alu_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_raddr1 (cmd_rs1),
        .o_rdata1 (w_rs1_data),
        .i_raddr2 (cmd_rs2),
        .o_rdata2 (w_rs2_data),
        .i_we     (w_wb),
        .i_waddr  (r_rd),
        .i_wdata  (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_rd        <= '0;
            r_wb_en     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_zero  <= 1'b0;
            r_rsp_rd    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_alu_a  <= w_rs1_data;
                        r_alu_b  <= cmd_use_imm ? cmd_imm : w_rs2_data;
                        r_alu_op <= cmd_op;
                        r_rd     <= cmd_rd;
                        r_wb_en  <= cmd_wb_en;
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_data  <= alu_result;
                    r_rsp_zero  <= alu_zero;
                    r_rsp_rd    <= r_rd;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_rd    = r_rsp_rd;

endmodule
